// File: rtl/sdiv16x16_seq_if.sv
// Handshake and operand/result bundle for the sequential signed/unsigned divider.
// The master drives the request side; the slave (divider) drives busy and results.
interface sdiv16x16_seq_if #(
    parameter int WIDTH = 16
);
    logic                    iStart;
    logic signed [WIDTH-1:0] iNum;
    logic        [WIDTH-1:0] iDen;
    logic                    oBusy;
    logic                    oValid;
    logic signed [WIDTH-1:0] oQuot;
    logic signed [WIDTH-1:0] oRem;
    logic                    oDivZero;

    modport master (
        output iStart, iNum, iDen,
        input  oBusy, oValid, oQuot, oRem, oDivZero
    );

    modport slave (
        input  iStart, iNum, iDen,
        output oBusy, oValid, oQuot, oRem, oDivZero
    );
endinterface

// File: rtl/sdiv16x16_seq.sv
// Sequential restoring divider: signed numerator / unsigned divisor, one quotient bit
// per clock, truncating result with a remainder that carries the numerator's sign.
module sdiv16x16_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    sdiv16x16_seq_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    logic        [WIDTH-1:0] mag;
    logic        [WIDTH-1:0] den;
    logic        [WIDTH:0]   r;
    logic        [CNT_W-1:0] cnt;
    logic                    negN;
    logic                    dz;
    logic signed [WIDTH-1:0] numRaw;

    logic        [WIDTH:0]   r_sh;
    logic        [WIDTH:0]   r_sub;
    logic                    take;

    logic                    valid_q;
    logic                    dz_q;
    logic signed [WIDTH-1:0] quot_q;
    logic signed [WIDTH-1:0] rem_q;

    function automatic logic signed [WIDTH-1:0] apply_sign(input logic neg,
                                                           input logic [WIDTH-1:0] m);
        return neg ? -$signed(m) : $signed(m);
    endfunction

    // Divide-by-zero result saturates towards the numerator's sign.
    function automatic logic signed [WIDTH-1:0] sat_divzero(input logic neg);
        return neg ? $signed({1'b1, {(WIDTH-1){1'b0}}}) : $signed({1'b0, {(WIDTH-1){1'b1}}});
    endfunction

    // r[WIDTH] is always 0 once a step completes; folding it into take keeps the
    // classic shifted-out-MSB rule without relying on that invariant.
    assign r_sh  = {r[WIDTH-1:0], mag[WIDTH-1]};
    assign r_sub = r_sh - {1'b0, den};
    assign take  = r[WIDTH] | (r_sh >= {1'b0, den});

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.iStart) state_nxt = (bus.iDen == '0) ? DONE : RUN;
            RUN:     if (cnt == '0)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag     <= '0;
            den     <= '0;
            r       <= '0;
            cnt     <= '0;
            negN    <= 1'b0;
            dz      <= 1'b0;
            numRaw  <= '0;
            valid_q <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.iStart) begin
                        // Unsigned magnitude: the most negative input maps to 2^(WIDTH-1).
                        mag    <= bus.iNum[WIDTH-1] ? $unsigned(-bus.iNum) : $unsigned(bus.iNum);
                        den    <= bus.iDen;
                        negN   <= bus.iNum[WIDTH-1];
                        numRaw <= bus.iNum;
                        r      <= '0;
                        dz     <= (bus.iDen == '0);
                        cnt    <= CNT_W'(WIDTH-1);
                    end
                end
                RUN: begin
                    r   <= take ? r_sub : r_sh;
                    mag <= {mag[WIDTH-2:0], take};
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                DONE: begin
                    valid_q <= 1'b1;
                    dz_q    <= dz;
                    if (dz) begin
                        quot_q <= sat_divzero(negN);
                        rem_q  <= numRaw;
                    end else begin
                        quot_q <= apply_sign(negN, mag);
                        rem_q  <= apply_sign(negN, r[WIDTH-1:0]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.oBusy    = (state != IDLE);
    assign bus.oValid   = valid_q;
    assign bus.oQuot    = quot_q;
    assign bus.oRem     = rem_q;
    assign bus.oDivZero = dz_q;
endmodule
